ex_alu_stage: RTL
=================

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid_in  input  1  operand/control bundle from ID/EX is valid this cycle.
REQ-005 Operation  input  4  ALU operation code from ALU control.
REQ-006 a  input  64  operand A.
REQ-007 b  input  64  operand B (register or immediate).
REQ-008 rd_in  input  5  destination register index.
REQ-009 reg_write_in  input  1  instruction writes the register file.
REQ-010 hold  input  1  downstream stall: freeze all state.
REQ-011 flush  input  1  kill the in-flight and incoming instruction.
REQ-012 result  output  64  registered ALU result.
REQ-013 zero  output  1  registered (result == 0).
REQ-014 rd_out  output  5  registered rd_in of the completed instruction.
REQ-015 reg_write_out  output  1  registered reg_write_in, gated by valid_out.
REQ-016 valid_out  output  1  result/zero/rd_out/reg_write_out are valid this cycle.
REQ-017 busy  output  1  combinational; 1 while state is SHIFT; hazard unit stalls upstream.

Function
REQ-018 Operation codes SHALL be: 0010 add a+b; 0110 sub a-b; 0000 and; 0001 or; 0111 shift-left-logical a by b[5:0]; any other code SHALL give result 0.
REQ-019 Add and sub SHALL wrap modulo 2^64; no carry or overflow output.
REQ-020 The FSM SHALL have two states, IDLE and SHIFT; reset enters IDLE.
REQ-021 In IDLE, when valid_in=1, hold=0 and flush=0, the bundle SHALL be accepted at that edge.
REQ-022 For single-cycle codes (all except 0111), the result SHALL be registered with valid_out=1 at the accepting edge: one-cycle latency.
REQ-023 For 0111 with b[5:0]=0, the result SHALL be a, with single-cycle latency.
REQ-024 For 0111 with b[5:0]=n>0, the accepting edge SHALL load acc=a, cnt=n, latch rd_in and reg_write_in, and enter SHIFT with valid_out=0.
REQ-025 Each SHIFT edge with hold=0 SHALL apply acc<=acc<<1 and cnt<=cnt-1.
REQ-026 At the SHIFT edge where cnt=1, result SHALL take acc<<1, valid_out SHALL be 1, and the FSM SHALL return to IDLE; total latency is n cycles after acceptance.
REQ-027 While busy=1, valid_in SHALL be ignored; upstream SHALL hold the next bundle until busy=0.
REQ-028 valid_out SHALL be a one-cycle pulse per completed instruction unless hold=1 extends it.
REQ-029 When no completion occurs (and hold=0), valid_out SHALL be 0 next cycle; result, zero and rd_out SHALL keep their last values.
REQ-030 reg_write_out SHALL equal valid_out AND the latched reg_write.
REQ-031 hold=1 SHALL freeze state, acc, cnt and all outputs, including an asserted valid_out.
REQ-032 flush=1 SHALL have priority over hold and valid_in.
REQ-033 flush=1 SHALL clear valid_out and reg_write_out at that edge, abort any SHIFT to IDLE, and accept nothing.
REQ-034 zero SHALL be computed from the value being written to result at the same edge.

Reset
REQ-035 On reset, the block SHALL set: state IDLE, acc 0, cnt 0, result 0, zero 1, rd_out 0, reg_write_out 0, valid_out 0.
REQ-036 Reset SHALL override flush, hold and valid_in.
REQ-037 Reset during SHIFT SHALL discard the in-flight shift with no completion pulse.

Verification
REQ-038 Add: a=5, b=7, Operation=0010, valid_in=1, rd_in=3, reg_write_in=1 -> next cycle result=12, zero=0, rd_out=3, reg_write_out=1, valid_out=1 for one cycle.
REQ-039 Sub to zero with wrap: a=b=64'h10, Operation=0110 -> result=0, zero=1. Then a=0, b=1 -> result=64'hFFFF_FFFF_FFFF_FFFF.
REQ-040 Multi-cycle shift: a=1, b=4, Operation=0111 -> busy=1 for 4 cycles and valid_in ignored; at the 4th edge result=16, valid_out=1, busy=0. Then b=0 -> result=a after 1 cycle.
REQ-041 Hold: assert hold=1 for 2 cycles in mid-SHIFT with a=3, b=3 -> completion delayed by 2 cycles, result=24. Hold with valid_out=1 -> valid_out stays 1.
REQ-042 Flush and reset: flush=1 in SHIFT -> busy=0 and valid_out=0 next cycle, no completion pulse. reset=1 with flush=1 and valid_in=1 -> all outputs at reset values, zero=1.
REQ-043 Unknown code: Operation=1111 with a=9, b=9 -> result=0, zero=1, valid_out=1.

Source files
------------

// File: rtl/ex_alu_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_alu_stage
// Description : Execute-stage ALU with a registered result. Add, sub, and
//               and or finish in one cycle. Shift-left-logical by a non-zero
//               amount is done one bit per cycle. While that shift runs, busy
//               is high and new bundles are ignored.
//
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   synchronous active-high reset
//   valid_in      in   1   ID/EX bundle valid
//   Operation     in   4   ALU operation code
//   a, b          in   64  operands (b[5:0] is the shift amount)
//   rd_in         in   5   destination register index
//   reg_write_in  in   1   instruction writes the register file
//   hold          in   1   downstream stall, freezes all state
//   flush         in   1   kill in-flight and incoming instruction
//   result        out  64  registered ALU result
//   zero          out  1   registered (result == 0)
//   rd_out        out  5   rd of the completed instruction
//   reg_write_out out  1   valid_out & latched reg_write
//   valid_out     out  1   outputs valid this cycle
//   busy          out  1   multi-cycle shift in progress
//
// Revision    : 1.0  initial release
// ============================================================================
module ex_alu_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [3:0]  Operation,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        hold,
    input  logic        flush,
    output logic [63:0] result,
    output logic        zero,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        valid_out,
    output logic        busy
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLL = 4'b0111;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [63:0] r_acc;
    logic [5:0]  r_cnt;
    logic [63:0] r_result;
    logic        r_zero;
    logic [4:0]  r_rd_out;
    logic        r_rw_out;
    logic        r_valid;
    // rd/reg_write of an in-flight shift. They are kept apart from rd_out so
    // the visible outputs keep their last values until the shift completes.
    logic [4:0]  r_rd_lat;
    logic        r_rw_lat;

    logic [63:0] w_alu;
    logic [63:0] w_acc_shl;
    logic        w_shift_multi;

    // Single-cycle ALU result. A shift by 0 falls out as a << 0 == a.
    always_comb begin
        w_alu = '0;
        case (Operation)
            c_OP_ADD: w_alu = a + b;
            c_OP_SUB: w_alu = a - b;
            c_OP_AND: w_alu = a & b;
            c_OP_OR:  w_alu = a | b;
            c_OP_SLL: w_alu = a << b[5:0];
            default:  w_alu = '0;
        endcase
    end

    assign w_shift_multi = (Operation == c_OP_SLL) && (b[5:0] != 6'd0);
    assign w_acc_shl     = {r_acc[62:0], 1'b0};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = c_ST_IDLE;
        end else if (!hold) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (valid_in && w_shift_multi) begin
                        w_state_next = c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (r_cnt == 6'd1) begin
                        w_state_next = c_ST_IDLE;
                    end
                end
                default: w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (r_state == c_ST_SHIFT);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_rd_out <= '0;
            r_rw_out <= 1'b0;
            r_valid  <= 1'b0;
            r_rd_lat <= '0;
            r_rw_lat <= 1'b0;
        end else if (flush) begin
            // Result, zero and rd_out keep their values; only the valid
            // indication is withdrawn.
            r_valid <= 1'b0;
        end else if (!hold) begin
            if (r_state == c_ST_SHIFT) begin
                r_acc <= w_acc_shl;
                r_cnt <= r_cnt - 6'd1;
                if (r_cnt == 6'd1) begin
                    r_result <= w_acc_shl;
                    r_zero   <= (w_acc_shl == 64'd0);
                    r_rd_out <= r_rd_lat;
                    r_rw_out <= r_rw_lat;
                    r_valid  <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end else if (valid_in) begin
                if (w_shift_multi) begin
                    r_acc    <= a;
                    r_cnt    <= b[5:0];
                    r_rd_lat <= rd_in;
                    r_rw_lat <= reg_write_in;
                    r_valid  <= 1'b0;
                end else begin
                    r_result <= w_alu;
                    r_zero   <= (w_alu == 64'd0);
                    r_rd_out <= rd_in;
                    r_rw_out <= reg_write_in;
                    r_valid  <= 1'b1;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign result        = r_result;
    assign zero          = r_zero;
    assign rd_out        = r_rd_out;
    assign valid_out     = r_valid;
    assign reg_write_out = r_valid & r_rw_out;

endmodule
`default_nettype wire
